mesh_seq: RTL and testbench

- Sequencer that drives the 64-node MAC mesh for iterated matrix-vector multiply, x(k+1) = M * x(k).
- Generates:
  - the mesh control vectors: sclrs, csels, asel, ressel, dinsel;
  - the matrix-BRAM read address;
  - the read/write addresses and write enables for the two ping-pong vector BRAMs.
- Runs a start/busy/done handshake with the host-side AXI register block.
- Vector length is fixed at NUM_NODES; each node produces one output element per iteration.

---
 rtl/mesh_seq.sv | 175 +++++++++++++++++
 tb/tb_mesh_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_seq.sv
// Sequencer for the MAC mesh: iterated x(k+1) = M * x(k) with ping-pong vector banks.
// Generates mesh clears/accumulate selects, matrix/vector BRAM addresses and bank write enables.
//
// state | meaning
// IDLE  | waiting for start; all controls low
// CLR   | clear every node accumulator
// FEED  | stream column k of M and element k of x into the mesh
// DRAIN | let the systolic stagger and MAC pipeline finish
// WB    | route node results to the destination bank, one per cycle
// SWAP  | flip source bank, count the iteration
// DONE  | one-cycle done pulse, final bank reported
module mesh_seq #(
   parameter int IDX_WIDTH_FOR_NODES = 6,
   parameter int NUM_NODES           = 2**IDX_WIDTH_FOR_NODES,
   parameter int MAC_LAT             = 3,
   parameter int ITER_WIDTH          = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [ITER_WIDTH-1:0]          iters,
   input  logic                           init_mode,
   output logic                           busy,
   output logic                           done,
   output logic                           res_bank,
   output logic [NUM_NODES-1:0]           sclrs,
   output logic [NUM_NODES-1:0]           csels,
   output logic [1:0]                     asel,
   output logic [IDX_WIDTH_FOR_NODES-1:0] ressel,
   output logic [1:0]                     dinsel,
   output logic [IDX_WIDTH_FOR_NODES-1:0] mbram_addr,
   output logic [IDX_WIDTH_FOR_NODES-1:0] vb_raddr,
   output logic                           vbram0_we,
   output logic                           vbram1_we,
   output logic [IDX_WIDTH_FOR_NODES-1:0] vb_waddr
);

   localparam int TMR_W = $clog2(NUM_NODES + MAC_LAT + 2) + 1;
   localparam logic [TMR_W-1:0] FEED_LD  = TMR_W'(NUM_NODES - 1);
   localparam logic [TMR_W-1:0] DRAIN_LD = TMR_W'(NUM_NODES + MAC_LAT - 1);
   localparam logic [TMR_W-1:0] WB_LD    = TMR_W'(NUM_NODES);
   localparam logic [TMR_W-1:0] N_T      = TMR_W'(NUM_NODES);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_FEED, S_DRAIN, S_WB, S_SWAP, S_DONE
   } state_t;

   state_t                state, state_nxt;
   logic [TMR_W-1:0]      tmr, tmr_ld;
   logic                  src;
   logic [ITER_WIDTH-1:0] iter_cnt, iters_q;
   logic                  init_q;
   logic [TMR_W-1:0]      feed_pos, drain_pos, wb_pos, wb_prev;
   int                    rel;

   // Positions within a state are recovered from the down-counter.
   assign feed_pos  = FEED_LD - tmr;
   assign drain_pos = DRAIN_LD - tmr;
   assign wb_pos    = WB_LD - tmr;
   assign wb_prev   = wb_pos - 1'b1;
   assign dinsel    = 2'b00;

   always_comb begin
      tmr_ld = '0;
      case (state_nxt)
         S_FEED:  tmr_ld = FEED_LD;
         S_DRAIN: tmr_ld = DRAIN_LD;
         S_WB:    tmr_ld = WB_LD;
         default: tmr_ld = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         tmr      <= '0;
         src      <= 1'b0;
         iter_cnt <= '0;
         iters_q  <= '0;
         init_q   <= 1'b0;
         res_bank <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state != state_nxt)
            tmr <= tmr_ld;
         else if (tmr != '0)
            tmr <= tmr - 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  iters_q  <= iters;
                  init_q   <= init_mode;
                  src      <= 1'b0;
                  iter_cnt <= '0;
                  if (iters == '0)
                     res_bank <= 1'b0;
               end
            end
            S_SWAP: begin
               src      <= ~src;
               iter_cnt <= iter_cnt + 1'b1;
               if (state_nxt == S_DONE)
                  res_bank <= ~src;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (iters == '0) ? S_DONE : S_CLR;
         S_CLR:   state_nxt = S_FEED;
         S_FEED:  if (tmr == '0) state_nxt = S_DRAIN;
         S_DRAIN: if (tmr == '0) state_nxt = S_WB;
         S_WB:    if (tmr == '0) state_nxt = S_SWAP;
         S_SWAP:  state_nxt = (({1'b0, iter_cnt} + 1'b1) == {1'b0, iters_q}) ? S_DONE : S_CLR;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Controls are gated by rst so nothing, in particular no bank write, escapes a reset cycle.
   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      sclrs      = '0;
      csels      = '0;
      asel       = 2'b00;
      ressel     = '0;
      mbram_addr = '0;
      vb_raddr   = '0;
      vbram0_we  = 1'b0;
      vbram1_we  = 1'b0;
      vb_waddr   = '0;
      rel        = -1;
      if (!rst) begin
         case (state)
            S_CLR: begin
               busy  = 1'b1;
               sclrs = '1;
            end
            S_FEED: begin
               busy       = 1'b1;
               mbram_addr = feed_pos[IDX_WIDTH_FOR_NODES-1:0];
               vb_raddr   = feed_pos[IDX_WIDTH_FOR_NODES-1:0];
               asel       = {init_q && (iter_cnt == '0), src};
               rel        = int'(feed_pos);
            end
            S_DRAIN: begin
               busy = 1'b1;
               rel  = NUM_NODES + int'(drain_pos);
            end
            S_WB: begin
               busy = 1'b1;
               if (wb_pos < N_T)
                  ressel = wb_pos[IDX_WIDTH_FOR_NODES-1:0];
               if (wb_pos != '0) begin
                  vb_waddr  = wb_prev[IDX_WIDTH_FOR_NODES-1:0];
                  vbram0_we = src;
                  vbram1_we = ~src;
               end
            end
            S_SWAP: busy = 1'b1;
            S_DONE: done = 1'b1;
            default: ;
         endcase
      end
      // Node i sees element k at FEED-relative cycle k+1+i.
      for (int i = 0; i < NUM_NODES; i++)
         csels[i] = (rel > i) && (rel <= i + NUM_NODES);
   end

endmodule

// File: tb/tb_mesh_seq.sv
// Directed bench for mesh_seq with a 4-node behavioural mesh and ping-pong bank model.
module tb_mesh_seq;
   localparam int IW = 2;
   localparam int N  = 4;
   localparam int ML = 3;
   localparam int ITW = 8;

   logic clk = 1'b0;
   logic rst, start, init_mode;
   logic [ITW-1:0] iters;
   logic busy, done, res_bank, vbram0_we, vbram1_we;
   logic [N-1:0] sclrs, csels;
   logic [1:0] asel, dinsel;
   logic [IW-1:0] ressel, mbram_addr, vb_raddr, vb_waddr;

   mesh_seq #(.IDX_WIDTH_FOR_NODES(IW), .NUM_NODES(N), .MAC_LAT(ML), .ITER_WIDTH(ITW)) dut (
      .clk(clk), .rst(rst), .start(start), .iters(iters), .init_mode(init_mode),
      .busy(busy), .done(done), .res_bank(res_bank), .sclrs(sclrs), .csels(csels),
      .asel(asel), .ressel(ressel), .dinsel(dinsel), .mbram_addr(mbram_addr),
      .vb_raddr(vb_raddr), .vbram0_we(vbram0_we), .vbram1_we(vbram1_we), .vb_waddr(vb_waddr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int m_mat [N][N];
   int init_vec [N];
   int x_vec [N];
   int bank0 [N];
   int bank1 [N];
   int acc [N];
   int a_sh [N];
   int k_sh [N];
   int rd_val, rd_idx;
   int wr0, wr1, rst_wr, wr_n;
   int wr_bank_log [16];
   int wr_addr_log [16];
   logic clr_log = 1'b0;
   logic load_req = 1'b0;

   // Behavioural mesh: 1-cycle BRAM read, operand shifted one node per cycle.
   always @(posedge clk) begin
      rd_val <= asel[1] ? init_vec[vb_raddr] : (asel[0] ? bank1[vb_raddr] : bank0[vb_raddr]);
      rd_idx <= int'(mbram_addr);
      a_sh[0] <= rd_val;
      k_sh[0] <= rd_idx;
      for (int i = 1; i < N; i++) begin
         a_sh[i] <= a_sh[i-1];
         k_sh[i] <= k_sh[i-1];
      end
      for (int i = 0; i < N; i++) begin
         if (sclrs[i])
            acc[i] <= 0;
         else if (csels[i])
            acc[i] <= acc[i] + m_mat[i][(i == 0) ? rd_idx : k_sh[i-1]] * ((i == 0) ? rd_val : a_sh[i-1]);
      end
      if (load_req)
         for (int i = 0; i < N; i++) bank0[i] <= x_vec[i];
      if (vbram0_we) bank0[vb_waddr] <= acc[vb_waddr];
      if (vbram1_we) bank1[vb_waddr] <= acc[vb_waddr];
      if (clr_log) begin
         wr0 <= 0; wr1 <= 0; wr_n <= 0; rst_wr <= 0;
      end else begin
         if (rst && (vbram0_we || vbram1_we)) rst_wr <= rst_wr + 1;
         if (vbram0_we) wr0 <= wr0 + 1;
         if (vbram1_we) wr1 <= wr1 + 1;
         if ((vbram0_we || vbram1_we) && wr_n < 16) begin
            wr_bank_log[wr_n] <= vbram1_we ? 1 : 0;
            wr_addr_log[wr_n] <= int'(vb_waddr);
            wr_n <= wr_n + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log(input logic load);
      clr_log = 1'b1;
      load_req = load;
      tick();
      clr_log = 1'b0;
      load_req = 1'b0;
   endtask

   task automatic matvec(input int v [N], output int r [N]);
      for (int i = 0; i < N; i++) begin
         r[i] = 0;
         for (int k = 0; k < N; k++) r[i] += m_mat[i][k] * v[k];
      end
   endtask

   task automatic wait_done(inout int cyc);
      while (done !== 1'b1 && cyc < 400) begin
         tick();
         cyc++;
      end
   endtask

   int cyc;
   int g1 [N];
   int g2 [N];
   int g3 [N];
   int pat_b, pat_a;

   initial begin
      m_mat = '{'{1, 2, 0, 1}, '{0, 1, 3, 0}, '{2, 0, 1, 1}, '{1, 1, 0, 2}};
      init_vec = '{1, 2, 3, 4};
      x_vec = '{2, 0, 1, 3};
      rst = 1'b1; start = 1'b0; iters = '0; init_mode = 1'b0;
      clr_log = 1'b1;
      tick(); tick(); tick();
      clr_log = 1'b0;
      rst = 1'b0;
      tick();
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_res_bank", res_bank, 0);
      chk("reset_sclrs", sclrs, 0);
      chk("reset_we", {vbram0_we, vbram1_we}, 0);

      // single iteration from the init port
      clear_log(1'b0);
      iters = 8'd1; init_mode = 1'b1; start = 1'b1;
      tick(); start = 1'b0; cyc = 1;
      chk("s1_clr_sclrs", sclrs, 4'hF);
      chk("s1_clr_busy", busy, 1);
      tick(); cyc++;
      chk("s1_feed0_asel", asel, 2'b10);
      chk("s1_feed0_csels", csels, 4'b0000);
      chk("s1_feed0_addr", mbram_addr, 0);
      tick(); tick(); cyc += 2;
      chk("s1_rel2_csels", csels, 4'b0011);
      chk("s1_rel2_raddr", vb_raddr, 2);
      tick(); tick(); tick(); cyc += 3;
      chk("s1_rel5_csels", csels, 4'b1110);
      wait_done(cyc);
      chk("s1_done_cycle", cyc, 19);
      chk("s1_busy_at_done", busy, 0);
      chk("s1_res_bank", res_bank, 1);
      chk("s1_wr_counts", {wr0[7:0], wr1[7:0]}, {8'd0, 8'd4});
      pat_a = 0;
      for (int i = 0; i < 4; i++) pat_a |= (wr_addr_log[i] & 3) << (2 * i);
      chk("s1_wr_addrs", pat_a, 8'b11_10_01_00);
      matvec(init_vec, g1);
      for (int i = 0; i < N; i++) chk($sformatf("s1_result[%0d]", i), bank1[i], g1[i]);
      tick();
      chk("s1_done_pulse", done, 0);

      // three iterations from bank 0
      clear_log(1'b1);
      iters = 8'd3; init_mode = 1'b0; start = 1'b1;
      tick(); start = 1'b0; cyc = 1;
      wait_done(cyc);
      chk("s3_done_cycle", cyc, 55);
      chk("s3_res_bank", res_bank, 1);
      chk("s3_wr_total", wr_n, 12);
      pat_b = 0;
      for (int i = 0; i < 12; i++) pat_b |= (wr_bank_log[i] & 1) << i;
      chk("s3_bank_seq", pat_b, 12'hF0F);
      matvec(x_vec, g1);
      matvec(g1, g2);
      matvec(g2, g3);
      for (int i = 0; i < N; i++) chk($sformatf("s3_result[%0d]", i), bank1[i], g3[i]);
      tick();

      // zero iterations
      clear_log(1'b0);
      iters = 8'd0; start = 1'b1;
      tick(); start = 1'b0;
      chk("z_done", done, 1);
      chk("z_busy", busy, 0);
      chk("z_res_bank", res_bank, 0);
      tick();
      chk("z_done_pulse", done, 0);
      chk("z_writes", wr0 + wr1, 0);

      // start re-pulsed during a run
      clear_log(1'b0);
      iters = 8'd1; init_mode = 1'b1; start = 1'b1;
      tick(); start = 1'b0; cyc = 1;
      tick(); tick(); cyc += 2;
      iters = 8'd7; start = 1'b1;
      tick(); start = 1'b0; cyc++;
      repeat (6) begin tick(); cyc++; end
      start = 1'b1;
      tick(); start = 1'b0; cyc++;
      wait_done(cyc);
      chk("rp_done_cycle", cyc, 19);
      chk("rp_writes", {wr0[7:0], wr1[7:0]}, {8'd0, 8'd4});
      chk("rp_res_bank", res_bank, 1);
      tick();
      chk("rp_no_rerun", busy, 0);

      // reset mid-FEED
      clear_log(1'b0);
      iters = 8'd2; init_mode = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick();
      rst = 1'b1; #1;
      chk("rf_rst_busy", busy, 0);
      chk("rf_rst_csels", csels, 0);
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
      chk("rf_idle_busy", busy, 0);
      chk("rf_idle_sclrs", sclrs, 0);
      chk("rf_res_bank", res_bank, 0);
      repeat (20) tick();
      chk("rf_no_writes", wr0 + wr1, 0);

      // reset during write-back suppresses the write
      iters = 8'd1; init_mode = 1'b1; start = 1'b1;
      tick(); start = 1'b0; cyc = 1;
      repeat (13) begin tick(); cyc++; end
      rst = 1'b1; #1;
      chk("rw_we_gated", {vbram0_we, vbram1_we}, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("rw_rst_writes", rst_wr, 0);
      chk("rw_idle_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
